// File: rtl/div_seq_ctrl.sv
// ============================================================================
//  Module   : div_seq_ctrl
//  Purpose  : Multi-cycle restoring-division sequencer for DIV. Drives an
//             external shared subtractor (A + ~B + 1) one trial subtraction
//             per cycle and assembles quotient and remainder.
//  Ports    : clock, clear        - clock / async active-high reset
//             start, signed_op    - request (sampled in IDLE), signedness
//             dividend, divisor   - operands, sampled with start
//             busy, done          - status (busy in RUN/FIX, done one pulse)
//             div_zero, quotient,
//             remainder           - results, held between operations
//             sub_en/sub_a/sub_b  - to shared subtractor (zero when idle)
//             sub_diff/sub_cout   - from shared subtractor
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq_ctrl #(
   parameter int               WIDTH    = 32,
   parameter int               CNT_W    = 6,
   parameter logic [WIDTH-1:0] DBZ_QUOT = 32'hFFFFFFFF
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             sub_en,
   output logic [WIDTH-1:0] sub_a,
   output logic [WIDTH-1:0] sub_b,
   input  logic [WIDTH-1:0] sub_diff,
   input  logic             sub_cout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   q_q, q_d;       // working dividend / quotient shift reg
   logic [WIDTH-1:0]   r_q, r_d;       // partial remainder
   logic [WIDTH-1:0]   dvs_q, dvs_d;   // divisor magnitude
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               dz_q, dz_d;

   logic [WIDTH-1:0]   w_shift_r;
   logic               w_ov;
   logic               w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b;

   // Bit shifted out of R; when set the true 33-bit partial remainder is
   // already >= divisor, and the modulo-2^WIDTH difference is exact.
   assign w_ov      = r_q[WIDTH-1];
   assign w_shift_r = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

   assign w_a_neg = signed_op & dividend[WIDTH-1];
   assign w_b_neg = signed_op & divisor[WIDTH-1];
   assign w_mag_a = w_a_neg ? (~dividend + WIDTH'(1)) : dividend;
   assign w_mag_b = w_b_neg ? (~divisor + WIDTH'(1)) : divisor;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dvs_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dvs_q   <= dvs_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dvs_d   = dvs_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      sub_en  = 1'b0;
      sub_a   = '0;
      sub_b   = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  quot_d  = DBZ_QUOT;
                  rem_d   = dividend;
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  dz_d    = 1'b0;
                  q_d     = w_mag_a;
                  r_d     = '0;
                  dvs_d   = w_mag_b;
                  q_neg_d = w_a_neg ^ w_b_neg;
                  r_neg_d = w_a_neg;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            sub_en = 1'b1;
            sub_a  = w_shift_r;
            sub_b  = dvs_q;
            if (w_ov || sub_cout) begin
               r_d = sub_diff;
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d = w_shift_r;
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == C_LAST_ITER) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FIX: begin
            // Truncating division: remainder carries the dividend's sign.
            quot_d  = q_neg_q ? (~q_q + WIDTH'(1)) : q_q;
            rem_d   = r_neg_q ? (~r_q + WIDTH'(1)) : r_q;
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy      = (state_q == S_RUN) || (state_q == S_FIX);
   assign done      = (state_q == S_DONE);
   assign div_zero  = dz_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
// ============================================================================
//  Module   : tb_div_seq_ctrl
//  Purpose  : Self-checking bench for div_seq_ctrl with an arithmetic
//             reference model, a per-cycle compare process and directed
//             literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq_ctrl;

   logic        clock = 1'b0;
   logic        clear;
   logic        start, signed_op;
   logic [31:0] dividend, divisor;
   logic        busy, done, div_zero, sub_en, sub_cout;
   logic [31:0] quotient, remainder, sub_a, sub_b, sub_diff;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_on  = 1'b0;

   div_seq_ctrl dut (
      .clock(clock), .clear(clear), .start(start), .signed_op(signed_op),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .div_zero(div_zero), .quotient(quotient), .remainder(remainder),
      .sub_en(sub_en), .sub_a(sub_a), .sub_b(sub_b),
      .sub_diff(sub_diff), .sub_cout(sub_cout)
   );

   // Shared subtractor datapath seen by the sequencer.
   assign {sub_cout, sub_diff} = {1'b0, sub_a} + {1'b0, ~sub_b} + 33'd1;

   always #5 clock = ~clock;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endfunction

   function automatic logic [31:0] mag(input logic s, input logic [31:0] v);
      return (s && v[31]) ? (~v + 32'd1) : v;
   endfunction

   function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      logic [31:0] ma, mb;
      ma = mag(s, a);
      mb = mag(s, b);
      q  = ma / mb;
      r  = ma % mb;
      if (s && (a[31] ^ b[31])) q = ~q + 32'd1;
      if (s && a[31])           r = ~r + 32'd1;
   endfunction

   // ---------------- reference model ----------------
   // age = number of edges since the accepting edge, plus one (0 = idle).
   int          age;
   logic        m_dbz, m_dz;
   logic [31:0] m_q, m_r, m_pq, m_pr, m_mb;

   always @(posedge clock or posedge clear) begin
      if (clear) begin
         age <= 0; m_dbz <= 1'b0; m_dz <= 1'b0;
         m_q <= '0; m_r <= '0; m_pq <= '0; m_pr <= '0; m_mb <= '0;
      end else if (age == 0) begin
         if (start) begin
            logic [31:0] tq, tr;
            age <= 1;
            if (divisor == 32'd0) begin
               m_dbz <= 1'b1; m_dz <= 1'b1;
               m_q <= 32'hFFFFFFFF; m_r <= dividend;
            end else begin
               ref_div(signed_op, dividend, divisor, tq, tr);
               m_dbz <= 1'b0; m_dz <= 1'b0;
               m_pq <= tq; m_pr <= tr; m_mb <= mag(signed_op, divisor);
            end
         end
      end else if (m_dbz || age == 34) begin
         age <= 0;
      end else begin
         age <= age + 1;
         if (age == 33) begin
            m_q <= m_pq; m_r <= m_pr;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      if (chk_on && !clear) begin
         logic e_run, e_busy, e_done;
         e_run  = !m_dbz && age >= 1 && age <= 32;
         e_busy = !m_dbz && age >= 1 && age <= 33;
         e_done = (age == 34) || (m_dbz && age == 1);
         chk("busy",      {31'd0, busy},     {31'd0, e_busy});
         chk("done",      {31'd0, done},     {31'd0, e_done});
         chk("sub_en",    {31'd0, sub_en},   {31'd0, e_run});
         chk("div_zero",  {31'd0, div_zero}, {31'd0, m_dz});
         chk("quotient",  quotient,  m_q);
         chk("remainder", remainder, m_r);
         chk("sub_b",     sub_b, e_run ? m_mb : 32'd0);
         if (!e_run) chk("sub_a_idle", sub_a, 32'd0);
      end
   end

   // Issue one operation; observe 40 cycles after the accepting edge.
   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int extra_at, output int lat, output int ndone, output int nsub);
      @(negedge clock); #1;
      start = 1'b1; signed_op = s; dividend = a; divisor = b;
      @(posedge clock); #1;
      start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = $urandom_range(0, 1);
      lat = 0; ndone = 0; nsub = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (sub_en) nsub++;
         if (done) begin
            ndone++;
            if (lat == 0) lat = i + 1;
         end
         #1 start = (i + 1 == extra_at);
      end
      start = 1'b0;
      if (lat == 0) begin
         n_total++;
         $display("FAIL timeout: got no done expected done within 40 cycles");
      end
   endtask

   initial begin
      int lat, nd, ns;
      clear = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_quot", quotient, 32'd0);
      chk("rst_rem",  remainder, 32'd0);
      chk("rst_suba", sub_a, 32'd0);
      #1 clear = 1'b0;
      chk_on = 1'b1;

      // Unsigned 100 / 7
      run_op(1'b0, 32'd100, 32'd7, 0, lat, nd, ns);
      chk("u100_7_lat", lat, 34); chk("u100_7_ndone", nd, 1); chk("u100_7_nsub", ns, 32);
      chk("u100_7_q", quotient, 32'd14); chk("u100_7_r", remainder, 32'd2);
      chk("u100_7_dz", {31'd0, div_zero}, 32'd0);

      // Signed -7 / 2
      run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0, lat, nd, ns);
      chk("s_m7_2_q", quotient, 32'hFFFFFFFD); chk("s_m7_2_r", remainder, 32'hFFFFFFFF);

      // ov path
      run_op(1'b0, 32'hFFFFFFFF, 32'h80000001, 0, lat, nd, ns);
      chk("ov_q", quotient, 32'd1); chk("ov_r", remainder, 32'h7FFFFFFE);

      // Signed overflow
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, lat, nd, ns);
      chk("sovf_q", quotient, 32'h80000000); chk("sovf_r", remainder, 32'd0);
      chk("sovf_dz", {31'd0, div_zero}, 32'd0);

      // Divide by zero, then a valid start clears div_zero
      run_op(1'b0, 32'h1234, 32'd0, 0, lat, nd, ns);
      chk("dbz_lat", lat, 1); chk("dbz_ndone", nd, 1);
      chk("dbz_dz", {31'd0, div_zero}, 32'd1);
      chk("dbz_q", quotient, 32'hFFFFFFFF); chk("dbz_r", remainder, 32'h1234);
      run_op(1'b0, 32'd20, 32'd6, 0, lat, nd, ns);
      chk("dbz_clr_dz", {31'd0, div_zero}, 32'd0);
      chk("dbz_clr_q", quotient, 32'd3); chk("dbz_clr_r", remainder, 32'd2);

      // Second start during RUN is ignored
      run_op(1'b0, 32'd1000, 32'd9, 5, lat, nd, ns);
      chk("ign_ndone", nd, 1); chk("ign_lat", lat, 34);
      chk("ign_q", quotient, 32'd111); chk("ign_r", remainder, 32'd1);

      // Asynchronous clear mid-RUN
      @(negedge clock); #1;
      start = 1'b1; signed_op = 1'b0; dividend = 32'd500; divisor = 32'd3;
      @(posedge clock); #1 start = 1'b0;
      repeat (9) @(posedge clock);
      #2 clear = 1'b1;
      #1;
      chk("clr_busy", {31'd0, busy}, 32'd0);
      chk("clr_suben", {31'd0, sub_en}, 32'd0);
      chk("clr_suba", sub_a, 32'd0);
      chk("clr_subb", sub_b, 32'd0);
      chk("clr_quot", quotient, 32'd0);
      chk("clr_rem", remainder, 32'd0);
      chk("clr_done", {31'd0, done}, 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock); #1 clear = 1'b0;
      run_op(1'b0, 32'd9, 32'd3, 0, lat, nd, ns);
      chk("post_clr_ndone", nd, 1);
      chk("post_clr_q", quotient, 32'd3); chk("post_clr_r", remainder, 32'd0);

      // Randomized operations
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a, b;
         logic s;
         int sel;
         s   = $urandom_range(0, 1);
         a   = $urandom;
         sel = $urandom_range(0, 9);
         case (sel)
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 15);
            3:       b = 32'h80000000 | $urandom;
            4:       b = 32'hFFFFFFFF;
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         if (sel == 5) a = 32'h80000000;
         run_op(s, a, b, (sel == 6) ? int'($urandom_range(1, 33)) : 0, lat, nd, ns);
         chk("rnd_ndone", nd, 1);
         chk("rnd_lat", lat, (b == 32'd0) ? 1 : 34);
         chk("rnd_nsub", ns, (b == 32'd0) ? 0 : 32);
      end

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle restoring-division sequencer for the DIV instruction.
- Does not subtract itself: it drives the shared 32-bit subtractor datapath (A + (~B+1), with an enable gate and carry out) through a dedicated port group.
- Runs one trial subtraction per cycle and assembles quotient and remainder.
- Sits beside the ALU; the control unit pulses start and waits for done before latching results into HI/LO.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold WIDTH.
- DBZ_QUOT, 32'hFFFFFFFF, quotient reported on divide-by-zero.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- signed_op  in  1  1 = two's-complement divide, 0 = unsigned.
- dividend  in  32  sampled with start.
- divisor  in  32  sampled with start.
- busy  out  1  high in RUN and FIX.
- done  out  1  one-cycle pulse; results valid from this cycle.
- div_zero  out  1  set with done when divisor == 0; held until next accepted start.
- quotient  out  32  result; held until next accepted start.
- remainder  out  32  result; held until next accepted start.
- sub_en  out  1  enable to the shared subtractor; high only in RUN.
- sub_a  out  32  minuend = partial remainder after shift; 0 when sub_en = 0.
- sub_b  out  32  subtrahend = divisor magnitude; 0 when sub_en = 0.
- sub_diff  in  32  subtractor sum output.
- sub_cout  in  1  subtractor carry out; 1 means sub_a >= sub_b (divisor is nonzero in RUN).

Behaviour:
- Reset (clear = 1, any time, asynchronous):
  - State goes to IDLE; counter = 0.
  - busy, done, div_zero, sub_en = 0.
  - quotient, remainder, sub_a, sub_b = 0.
  - A clear in the middle of RUN abandons the operation; no done pulse is produced.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On start, latch the operands. If signed_op = 1, take magnitudes and record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - If divisor == 0: go to DONE with quotient = DBZ_QUOT, remainder = raw dividend, div_zero = 1. done therefore appears the cycle after start.
  - Otherwise: Q = |dividend|, R = 0, overflow bit ov = 0, counter = 0, go to RUN.
- RUN, one iteration per cycle, 32 cycles:
  - Form the shifted value {ov, R, Q} << 1. The new R is driven on sub_a.
  - If ov = 1 or sub_cout = 1: R <= sub_diff and the quotient LSB = 1.
  - Otherwise R is kept and the quotient LSB = 0.
  - ov handles the case where the 33-bit partial remainder exceeds 32 bits (divisor MSB set). Subtraction modulo 2^32 is then exact.
  - After counter == 31, go to FIX.
- FIX, 1 cycle:
  - Negate Q if q_neg; negate R if r_neg (truncating division; the remainder takes the dividend's sign).
  - Load quotient and remainder; go to DONE.
- DONE, 1 cycle: done = 1, busy = 0; go to IDLE.
- Latency: start sampled at edge k → busy from k+1 → RUN cycles k+1..k+32 → FIX at k+33 → done at k+34. Divide-by-zero gives done at k+1.
- start while busy, or during DONE, is ignored. It is not queued.
- Signed overflow: -2^31 / -1 gives quotient 0x80000000, remainder 0, with no flag.
- Outputs change only in FIX, or on the DONE entry for divide-by-zero. They are stable between operations.

Test Plan:
- Unsigned 100 / 7 → done at k+34; quotient = 14, remainder = 2, div_zero = 0; sub_en high for exactly 32 cycles.
- Signed -7 / 2 (0xFFFFFFF9, 0x2) → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- Unsigned 0xFFFFFFFF / 0x80000001 (exercises the ov path) → quotient 1, remainder 0x7FFFFFFE. Also check signed -2^31 / -1 → quotient 0x80000000, remainder 0.
- Divisor 0 with dividend 0x1234 → done at k+1, div_zero = 1, quotient 0xFFFFFFFF, remainder 0x1234. The next valid start clears div_zero.
- A second start pulse at k+5 during RUN is ignored → the first result is unchanged and exactly one done pulse occurs.
- clear asserted asynchronously at k+10 mid-RUN → all outputs 0 immediately, no done. A fresh start after release computes 9 / 3 → quotient 3, remainder 0.
